// File: rtl/uart_serial_rx_deframer.sv
// UART receive deframer: 16x oversampled start/data/parity/stop recovery with
// majority voting, error and break flagging, and a small character FIFO.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   srx_pad_i            serial line (idles high)
//   cfg_*                frame format, captured at the start of each frame
//   rx_data_o / rx_*_o   head FIFO entry (all zero while the FIFO is empty)
//   rx_valid_o           FIFO not empty
//   rx_ready_i           consumer accepts the head entry
//   rx_overrun_o         sticky "character dropped" flag
//   clr_overrun_i        clears rx_overrun_o (a coincident set wins)
module uart_serial_rx_deframer #(
    parameter int unsigned CLK_DIV    = 27,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       srx_pad_i,
    input  logic [3:0] cfg_n_bits_i,
    input  logic       cfg_parity_en_i,
    input  logic       cfg_parity_odd_i,
    input  logic       cfg_two_stop_i,
    output logic [7:0] rx_data_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_break_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       rx_overrun_o,
    input  logic       clr_overrun_i
);

    localparam int unsigned DIV_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
    localparam int unsigned AW    = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int unsigned PW    = AW + 1;

    typedef struct packed {
        logic       brk;
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_HOLD
    } state_t;

    // Two-flop line synchroniser; idles high out of reset.
    logic sync_q1;
    logic line_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q1 <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            sync_q1 <= srx_pad_i;
            line_q  <= sync_q1;
        end
    end

    // Free-running 16x oversampling tick.
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == DIV_W'(CLK_DIV));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // Out-of-range character lengths fall back to 8 bits.
    logic [2:0] n_last_cfg;
    assign n_last_cfg = (cfg_n_bits_i >= 4'd5 && cfg_n_bits_i <= 4'd8)
                        ? 3'(cfg_n_bits_i - 4'd1) : 3'd7;

    state_t     state_q, state_d;
    logic [3:0] sub_q, sub_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       s7_q, s7_d, s8_q, s8_d;
    logic       bit_val_q, bit_val_d;
    logic       par_bit_q, par_bit_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       brk_q, brk_d;
    logic [2:0] n_last_q, n_last_d;
    logic       par_en_q, par_en_d;
    logic       par_odd_q, par_odd_d;
    logic       two_stop_q, two_stop_d;
    logic       maj;
    logic       push;
    rx_entry_t  push_entry;

    // Frame state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            sub_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            s7_q       <= 1'b0;
            s8_q       <= 1'b0;
            bit_val_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            n_last_q   <= 3'd7;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            bit_val_q  <= bit_val_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            n_last_q   <= n_last_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
        end
    end

    // Next-state logic. Bits are voted from sub-ticks 7/8/9; the vote is final
    // at sub-tick 9 (third sample is the live line) and committed at 15.
    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        bit_val_d  = bit_val_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        n_last_d   = n_last_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        push       = 1'b0;
        maj        = (s7_q & s8_q) | (s7_q & line_q) | (s8_q & line_q);

        if (tick) begin
            sub_d = sub_q + 4'd1;
            if (sub_q == 4'd7) s7_d = line_q;
            if (sub_q == 4'd8) s8_d = line_q;
            if (sub_q == 4'd9) bit_val_d = maj;

            case (state_q)
                S_IDLE: begin
                    sub_d = '0;
                    if (!line_q) state_d = S_START;
                end
                S_START: begin
                    if (sub_q == 4'd9 && maj) begin
                        state_d = S_IDLE;
                    end else if (sub_q == 4'd15) begin
                        state_d    = S_DATA;
                        bit_d      = '0;
                        shift_d    = '0;
                        par_bit_d  = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        brk_d      = 1'b0;
                        n_last_d   = n_last_cfg;
                        par_en_d   = cfg_parity_en_i;
                        par_odd_d  = cfg_parity_odd_i;
                        two_stop_d = cfg_two_stop_i;
                    end
                end
                S_DATA: begin
                    if (sub_q == 4'd15) begin
                        shift_d[bit_q] = bit_val_q;
                        bit_d          = bit_q + 3'd1;
                        if (bit_q == n_last_q) state_d = par_en_q ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (sub_q == 4'd15) begin
                        par_bit_d = bit_val_q;
                        perr_d    = ((^shift_q) ^ bit_val_q) != par_odd_q;
                        state_d   = S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (sub_q == 4'd9) begin
                        ferr_d = ~maj;
                        brk_d  = ~maj & (shift_q == 8'd0) & ~(par_en_q & par_bit_q);
                        // Single stop: release early so the next start edge is caught.
                        if (!two_stop_q) begin
                            push    = 1'b1;
                            state_d = brk_d ? S_HOLD : S_IDLE;
                        end
                    end else if (sub_q == 4'd15) begin
                        state_d = S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (sub_q == 4'd9) begin
                        if (!maj) ferr_d = 1'b1;
                        push    = 1'b1;
                        state_d = brk_q ? S_HOLD : S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Do not re-arm on a line that is still held in break.
                    sub_d = '0;
                    if (line_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        push_entry.brk        = brk_d;
        push_entry.frame_err  = ferr_d;
        push_entry.parity_err = perr_d;
        push_entry.data       = shift_q;
    end

    // Character FIFO; extra pointer MSB separates full from empty.
    rx_entry_t     mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
    logic          full, pop, do_push, ovr_set, next_empty;
    rx_entry_t     head_d;

    assign full       = ((wr_q - rd_q) == PW'(FIFO_DEPTH));
    assign pop        = rx_valid_o & rx_ready_i;
    assign do_push    = push & (~full | pop);
    assign ovr_set    = push & full & ~pop;
    assign wr_d       = wr_q + PW'(do_push);
    assign rd_d       = rd_q + PW'(pop);
    assign next_empty = (wr_d == rd_d);

    // Next head entry; a push into an empty FIFO bypasses the storage array.
    always_comb begin
        head_d = '0;
        if (!next_empty) begin
            if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = push_entry;
            else                                            head_d = mem_q[rd_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_entry;
    end

    // Pointers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q            <= '0;
            rd_q            <= '0;
            rx_valid_o      <= 1'b0;
            rx_data_o       <= '0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_break_o      <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            wr_q            <= wr_d;
            rd_q            <= rd_d;
            rx_valid_o      <= ~next_empty;
            rx_data_o       <= head_d.data;
            rx_parity_err_o <= head_d.parity_err;
            rx_frame_err_o  <= head_d.frame_err;
            rx_break_o      <= head_d.brk;
            if (ovr_set)            rx_overrun_o <= 1'b1;
            else if (clr_overrun_i) rx_overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_serial_rx_deframer.sv
// Bench for uart_serial_rx_deframer: serial frame driver with a character-level
// reference model feeding a scoreboard queue; a monitor pops on each handshake.
module tb_uart_serial_rx_deframer;

    localparam int unsigned CLK_DIV    = 5;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TICK       = CLK_DIV + 1;
    localparam int unsigned BIT        = 16 * TICK;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       srx = 1'b1;
    logic [3:0] cfg_n_bits = 4'd8;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_two_stop = 1'b0;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_break;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       clr_overrun = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          model_occ = 0;
    int          ready_mode = 0;
    logic        exp_overrun = 1'b0;
    logic [10:0] exp_q[$];

    uart_serial_rx_deframer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .srx_pad_i        (srx),
        .cfg_n_bits_i     (cfg_n_bits),
        .cfg_parity_en_i  (cfg_parity_en),
        .cfg_parity_odd_i (cfg_parity_odd),
        .cfg_two_stop_i   (cfg_two_stop),
        .rx_data_o        (rx_data),
        .rx_parity_err_o  (rx_parity_err),
        .rx_frame_err_o   (rx_frame_err),
        .rx_break_o       (rx_break),
        .rx_valid_o       (rx_valid),
        .rx_ready_i       (rx_ready),
        .rx_overrun_o     (rx_overrun),
        .clr_overrun_i    (clr_overrun)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Model FIFO: a character arriving while the model holds DEPTH entries is dropped.
    task automatic expect_entry(input logic [10:0] e);
        if (model_occ >= int'(FIFO_DEPTH)) begin
            exp_overrun = 1'b1;
        end else begin
            exp_q.push_back(e);
            model_occ++;
        end
    endtask

    task automatic drive_bit(input logic b);
        srx = b;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int nbits);
        for (int i = 0; i < nbits; i++) drive_bit(1'b1);
    endtask

    // Sends one frame and records the character the receiver should report.
    task automatic send_frame(input logic [7:0] d, input logic [3:0] nb, input logic pen,
                              input logic podd, input logic two, input logic pflip,
                              input logic stop_v);
        int          n;
        logic [7:0]  m;
        logic        p;
        logic        brk;
        n   = (nb >= 4'd5 && nb <= 4'd8) ? int'(nb) : 8;
        m   = d & 8'((32'd1 << n) - 32'd1);
        p   = (^m) ^ podd ^ pflip;
        brk = (m == 8'd0) && (!pen || !p) && !stop_v;
        cfg_n_bits     = nb;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_two_stop   = two;
        expect_entry({brk, ~stop_v, pen & pflip, m});
        drive_bit(1'b0);
        for (int i = 0; i < n; i++) drive_bit(m[i]);
        if (pen) drive_bit(p);
        drive_bit(stop_v);
        if (two) drive_bit(stop_v);
    endtask

    task automatic drain(input string name);
        ready_mode = 1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic monitor();
        logic [10:0] got;
        logic [10:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && rx_valid && rx_ready) begin
                got = {rx_break, rx_frame_err, rx_parity_err, rx_data};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_char: got 0x%0h, nothing expected", got);
                end else begin
                    exp = exp_q.pop_front();
                    model_occ--;
                    check("rx_char", 32'(got), 32'(exp));
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    initial begin
        fork
            monitor();
            ready_driver();
        join_none

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", 32'({rx_valid, rx_overrun, rx_break, rx_frame_err,
                                    rx_parity_err, rx_data}), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 8N1 0xA5, held in the FIFO until the consumer is enabled
        ready_mode = 0;
        check("a5_idle_valid", 32'(rx_valid), 32'd0);
        send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("a5_valid_by_stop_end", 32'(rx_valid), 32'd1);
        idle(1);
        drain("drain_a5");

        // Glitch rejection, then 0x3C
        srx = 1'b0;
        repeat (3 * TICK) @(posedge clk);
        #1;
        idle(2);
        check("glitch_no_push", 32'({rx_valid, rx_break, rx_frame_err, rx_parity_err, rx_data}), 32'd0);
        send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drain("drain_3c");

        // 7E2: good parity, then flipped parity
        send_frame(8'h55, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        send_frame(8'h55, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);
        drain("drain_7e2");

        // Framing error without break
        send_frame(8'h81, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        drain("drain_81");

        // Line low for 20 bit times: one break entry only
        cfg_n_bits = 4'd8; cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
        expect_entry({1'b1, 1'b1, 1'b0, 8'h00});
        for (int i = 0; i < 20; i++) drive_bit(1'b0);
        idle(2);
        drain("drain_break");

        // Overrun with the consumer stalled
        ready_mode = 0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        check("overrun_set", 32'(rx_overrun), 32'(exp_overrun));
        drain("drain_overrun");
        check("overrun_sticky", 32'(rx_overrun), 32'(exp_overrun));
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        clr_overrun = 1'b0;
        exp_overrun = 1'b0;
        check("overrun_cleared", 32'(rx_overrun), 32'(exp_overrun));

        // Async reset mid-frame with a character pending
        ready_mode = 0;
        send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("pre_reset_valid", 32'(rx_valid), 32'(model_occ != 0));
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        srx = 1'b1;
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame", 32'({rx_valid, rx_overrun, rx_break, rx_frame_err,
                                      rx_parity_err, rx_data}), 32'd0);
        exp_q.delete();
        model_occ   = 0;
        exp_overrun = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        ready_mode = 1;
        send_frame(8'h96, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        drain("drain_96");

        // Randomized formats, errors and consumer back-pressure
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            send_frame(8'($urandom), 4'($urandom_range(3, 10)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            idle(2);
        end
        drain("drain_random");
        check("final_overrun", 32'(rx_overrun), 32'(exp_overrun));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
